// File: rtl/reg_reverse_ctrl_if.sv
// Host/swap-file bundle for the range-reversal sequencer: command inputs, swap request outputs, status.
// master = host side (drives start/lo/hi), slave = sequencer side.
interface reg_reverse_ctrl_if #(
  parameter int address_width = 7
);
  logic                     start;
  logic [address_width-1:0] lo;
  logic [address_width-1:0] hi;
  logic [address_width-1:0] address_a;
  logic [address_width-1:0] address_b;
  logic                     swap;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [address_width-1:0] swap_count;

  modport master (
    output start, lo, hi,
    input  address_a, address_b, swap, busy, done, err, swap_count
  );

  modport slave (
    input  start, lo, hi,
    output address_a, address_b, swap, busy, done, err, swap_count
  );
endinterface

// File: rtl/reg_reverse_ctrl.sv
// Reverses a swap-file address range by issuing (lo,hi),(lo+1,hi-1),... swap pulses, one every SWAP_CYCLES.
// First swap 1 cycle after start; done 1+N*SWAP_CYCLES after start; start outside IDLE is dropped, not queued.
module reg_reverse_ctrl #(
  parameter int address_width = 7,
  parameter int SWAP_CYCLES   = 4
) (
  input logic              clk,
  input logic              reset,
  reg_reverse_ctrl_if.slave ctl
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_REJECT = 3'd4;

  localparam int WCW = (SWAP_CYCLES > 2) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SWAP_CYCLES - 2);
  localparam logic [address_width-1:0] PTR_ONE = address_width'(1);

  logic [2:0]               state;
  logic [address_width-1:0] a_ptr;
  logic [address_width-1:0] b_ptr;
  logic [address_width-1:0] addr_a;
  logic [address_width-1:0] addr_b;
  logic [address_width-1:0] cnt;
  logic [WCW-1:0]           wait_cnt;
  logic [address_width-1:0] a_nxt;
  logic [address_width-1:0] b_nxt;
  logic                     range_bad;
  logic                     range_one;

  // a_ptr < b_ptr whenever a_nxt/b_nxt are used, so neither step can wrap.
  assign a_nxt     = a_ptr + PTR_ONE;
  assign b_nxt     = b_ptr - PTR_ONE;
  assign range_bad = (ctl.lo == '0) || (ctl.lo > ctl.hi);
  assign range_one = (ctl.lo == ctl.hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      a_ptr    <= '0;
      b_ptr    <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl.start) begin
            a_ptr <= ctl.lo;
            b_ptr <= ctl.hi;
            cnt   <= '0;
            if (range_bad) begin
              state <= S_REJECT;
            end else if (range_one) begin
              state <= S_DONE;
            end else begin
              state  <= S_ISSUE;
              addr_a <= ctl.lo;
              addr_b <= ctl.hi;
            end
          end
        end
        S_ISSUE: begin
          cnt      <= cnt + PTR_ONE;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            a_ptr <= a_nxt;
            b_ptr <= b_nxt;
            // Addresses only move when another swap is issued, so they hold the last pair afterwards.
            if (a_nxt < b_nxt) begin
              state  <= S_ISSUE;
              addr_a <= a_nxt;
              addr_b <= b_nxt;
            end else begin
              state <= S_DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_DONE:   state <= S_IDLE;
        S_REJECT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign ctl.address_a  = addr_a;
  assign ctl.address_b  = addr_b;
  assign ctl.swap_count = cnt;
  assign ctl.swap       = (state == S_ISSUE);
  assign ctl.busy       = (state == S_ISSUE) || (state == S_WAIT);
  assign ctl.done       = (state == S_DONE) || (state == S_REJECT);
  assign ctl.err        = (state == S_REJECT);

endmodule

// File: tb/tb_reg_reverse_ctrl.sv
// Directed bench for reg_reverse_ctrl with a behavioural swap register file hanging off the swap port.
module tb_reg_reverse_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  reg_reverse_ctrl_if #(.address_width(7)) bus ();

  reg_reverse_ctrl #(.address_width(7), .SWAP_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= i[6:0];
    end else if (bus.swap === 1'b1) begin
      mem[bus.address_a] <= mem[bus.address_b];
      mem[bus.address_b] <= mem[bus.address_a];
    end
  end

  int         sc[$];
  logic [6:0] sa[$];
  logic [6:0] sb[$];
  int         done_cyc;
  logic       err_done;
  logic       busy_done;
  logic [6:0] cnt_done;
  int         busy_bad;
  int         hold_bad;
  int         err_stray;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one command, logs every swap pulse, returns at the negedge of the done cycle.
  task automatic run_cmd(input int l, input int h, input int restart_at, input int budget);
    sc.delete(); sa.delete(); sb.delete();
    done_cyc = -1; err_done = 1'bx; busy_done = 1'bx; cnt_done = 'x;
    busy_bad = 0; hold_bad = 0; err_stray = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.lo = l[6:0]; bus.hi = h[6:0];
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      if (c == restart_at) begin
        bus.lo = 7'd2; bus.hi = 7'd3;
      end
      if (bus.swap === 1'b1) begin
        sc.push_back(c); sa.push_back(bus.address_a); sb.push_back(bus.address_b);
      end else if (bus.busy === 1'b1 && sa.size() > 0 &&
                   (bus.address_a !== sa[$] || bus.address_b !== sb[$])) begin
        hold_bad++;
      end
      if (bus.err === 1'b1 && bus.done !== 1'b1) err_stray++;
      if (bus.done === 1'b1) begin
        done_cyc = c; err_done = bus.err; busy_done = bus.busy; cnt_done = bus.swap_count;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    bus.start = 1'b0; bus.lo = '0; bus.hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_swap", bus.swap, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_addr_a", bus.address_a, 7'd0);
    check("rst_addr_b", bus.address_b, 7'd0);
    check("rst_count", bus.swap_count, 7'd0);

    // 1) lo=1 hi=4: swaps at 1 and 5, done at 9
    run_cmd(1, 4, 0, 40);
    check("t1_nswap", sc.size(), 2);
    check("t1_sc0", sc[0], 1);
    check("t1_sa0", sa[0], 1);
    check("t1_sb0", sb[0], 4);
    check("t1_sc1", sc[1], 5);
    check("t1_sa1", sa[1], 2);
    check("t1_sb1", sb[1], 3);
    check("t1_done", done_cyc, 9);
    check("t1_err", err_done, 1'b0);
    check("t1_busy_done", busy_done, 1'b0);
    check("t1_count", cnt_done, 7'd2);
    check("t1_busy_run", busy_bad, 0);
    check("t1_hold", hold_bad, 0);
    check("t1_err_stray", err_stray, 0);
    // start while in DONE must be dropped
    bus.start = 1'b1; bus.lo = 7'd1; bus.hi = 7'd4;
    @(negedge clk);
    bus.start = 1'b0;
    check("t1_done_pulse", bus.done, 1'b0);
    check("t1_ign_busy", bus.busy, 1'b0);
    check("t1_ign_swap", bus.swap, 1'b0);
    @(negedge clk);
    check("t1_ign_busy2", bus.busy, 1'b0);
    check("t1_ign_swap2", bus.swap, 1'b0);
    check("t1_addr_keep", bus.address_a, 7'd2);

    // 4) lo=0 rejected; swap_count cleared from the previous 2
    run_cmd(0, 3, 0, 10);
    check("t4_done", done_cyc, 1);
    check("t4_err", err_done, 1'b1);
    check("t4_nswap", sc.size(), 0);
    check("t4_count", cnt_done, 7'd0);
    check("t4_addr_keep", bus.address_a, 7'd2);

    // 3) single-address range and inverted range
    run_cmd(5, 5, 0, 10);
    check("t3a_done", done_cyc, 1);
    check("t3a_err", err_done, 1'b0);
    check("t3a_nswap", sc.size(), 0);
    check("t3a_count", cnt_done, 7'd0);
    run_cmd(6, 2, 0, 10);
    check("t3b_done", done_cyc, 1);
    check("t3b_err", err_done, 1'b1);
    check("t3b_nswap", sc.size(), 0);

    // 2) lo=3 hi=7 reverses 3..7 in the model register file, 5 untouched
    @(negedge clk); mem_init = 1'b1;
    @(negedge clk); mem_init = 1'b0;
    run_cmd(3, 7, 0, 40);
    check("t2_nswap", sc.size(), 2);
    check("t2_sa0", sa[0], 3);
    check("t2_sb0", sb[0], 7);
    check("t2_sa1", sa[1], 4);
    check("t2_sb1", sb[1], 6);
    check("t2_done", done_cyc, 9);
    check("t2_count", cnt_done, 7'd2);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("t2_mem%0d", i), mem[i], (i >= 3 && i <= 7) ? 10 - i : i);
    end

    // 5) restart at cycle 3 ignored
    run_cmd(1, 6, 3, 40);
    check("t5_nswap", sc.size(), 3);
    check("t5_sa2", sa[2], 3);
    check("t5_sb2", sb[2], 4);
    check("t5_sc2", sc[2], 9);
    check("t5_done", done_cyc, 13);
    check("t5_count", cnt_done, 7'd3);
    check("t5_busy_run", busy_bad, 0);

    // boundaries: top two addresses, and the full legal range
    run_cmd(126, 127, 0, 20);
    check("tb_top_nswap", sc.size(), 1);
    check("tb_top_sa0", sa[0], 126);
    check("tb_top_done", done_cyc, 5);
    run_cmd(1, 127, 0, 400);
    check("tf_nswap", sc.size(), 63);
    check("tf_sc62", sc[62], 249);
    check("tf_sa62", sa[62], 63);
    check("tf_sb62", sb[62], 65);
    check("tf_done", done_cyc, 253);
    check("tf_count", cnt_done, 7'd63);
    check("tf_hold", hold_bad, 0);

    // 6) reset at cycle 6 of lo=1 hi=6 aborts the sequence
    @(negedge clk);
    bus.start = 1'b1; bus.lo = 7'd1; bus.hi = 7'd6;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) check("t6_swap5", bus.swap, 1'b1);
      if (c == 6) reset = 1'b1;
    end
    @(negedge clk);
    check("t6_busy", bus.busy, 1'b0);
    check("t6_swap", bus.swap, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check("t6_count", bus.swap_count, 7'd0);
    check("t6_addr_a", bus.address_a, 7'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_swap", bus.swap, 1'b0);
    run_cmd(2, 5, 0, 40);
    check("t6_nswap", sc.size(), 2);
    check("t6_sa0", sa[0], 2);
    check("t6_sb0", sb[0], 5);
    check("t6_sc1", sc[1], 5);
    check("t6_done_new", done_cyc, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
